// File: rtl/if_mem_arbiter_if.sv
// rtl/if_mem_arbiter_if.sv - icache / PTW / memory-port signal bundle for if_mem_arbiter
interface if_mem_arbiter_if #(
  parameter int XLEN = 32
);
  // icache refill client
  logic            ic_req_i;
  logic [XLEN-1:0] ic_addr_i;
  logic            ic_kill_i;
  logic            ic_ack_o;
  logic [XLEN-1:0] ic_rdata_o;

  // page-table-walk client
  logic            ptw_req_i;
  logic [XLEN-1:0] ptw_addr_i;
  logic            ptw_ack_o;
  logic [XLEN-1:0] ptw_rdata_o;

  // shared memory port
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_ack_i;
  logic [XLEN-1:0] mem_rdata_i;

  // Arbiter's view of the bundle
  modport slave (
    input  ic_req_i, ic_addr_i, ic_kill_i,
    input  ptw_req_i, ptw_addr_i,
    input  mem_ack_i, mem_rdata_i,
    output ic_ack_o, ic_rdata_o,
    output ptw_ack_o, ptw_rdata_o,
    output mem_req_o, mem_addr_o
  );

  // Clients' and memory's view of the bundle
  modport master (
    output ic_req_i, ic_addr_i, ic_kill_i,
    output ptw_req_i, ptw_addr_i,
    output mem_ack_i, mem_rdata_i,
    input  ic_ack_o, ic_rdata_o,
    input  ptw_ack_o, ptw_rdata_o,
    input  mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/if_mem_arbiter.sv
// rtl/if_mem_arbiter.sv - round-robin arbiter of icache refills and PTW reads onto one memory port
module if_mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  if_mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY_IC  = 2'd1;
  localparam logic [1:0] BUSY_PTW = 2'd2;
  localparam logic [1:0] DRAIN    = 2'd3;

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic            last_ptw_q;   // 1: PTW was granted last, so icache wins the next tie
  logic [XLEN-1:0] addr_q;
  logic            ic_eligible;
  logic            grant_ic;
  logic            grant_ptw;
  logic            ic_hit;
  logic            ptw_hit;

  // A request raised together with its own kill is not a candidate.
  assign ic_eligible = bus.ic_req_i & ~bus.ic_kill_i;

  // Grants only happen from IDLE; on a tie the client not served last wins.
  assign grant_ic  = (state_q == IDLE) & ic_eligible & (~bus.ptw_req_i | last_ptw_q);
  assign grant_ptw = (state_q == IDLE) & bus.ptw_req_i & (~ic_eligible | ~last_ptw_q);

  // Response steering: a killed icache transaction never produces an ack.
  assign ic_hit  = (state_q == BUSY_IC) & bus.mem_ack_i & ~bus.ic_kill_i;
  assign ptw_hit = (state_q == BUSY_PTW) & bus.mem_ack_i;

  // Next-state decode for the single-outstanding transaction FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_ic) begin
          state_d = BUSY_IC;
        end else if (grant_ptw) begin
          state_d = BUSY_PTW;
        end
      end
      BUSY_IC: begin
        // The memory still owes a response after a kill, so it must be drained.
        if (bus.mem_ack_i) begin
          state_d = IDLE;
        end else if (bus.ic_kill_i) begin
          state_d = DRAIN;
        end
      end
      BUSY_PTW: begin
        if (bus.mem_ack_i) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (bus.mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register; reset abandons any outstanding transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Last-grant register for the round-robin tie-break.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ptw_q <= 1'b1;
    end else if (grant_ic) begin
      last_ptw_q <= 1'b0;
    end else if (grant_ptw) begin
      last_ptw_q <= 1'b1;
    end
  end

  // Address captured at grant and held stable for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (grant_ic) begin
      addr_q <= bus.ic_addr_i;
    end else if (grant_ptw) begin
      addr_q <= bus.ptw_addr_i;
    end
  end

  assign bus.mem_req_o   = (state_q != IDLE);
  assign bus.mem_addr_o  = addr_q;
  assign bus.ic_ack_o    = ic_hit;
  assign bus.ic_rdata_o  = ic_hit ? bus.mem_rdata_i : '0;
  assign bus.ptw_ack_o   = ptw_hit;
  assign bus.ptw_rdata_o = ptw_hit ? bus.mem_rdata_i : '0;

endmodule

// File: doc/if_mem_arbiter.md
IF_MEM_ARBITER -- requirements
Module: if_mem_arbiter

Interface
REQ-001 Parameter: XLEN, 32, address/data width.
REQ-002 Port: clk  input  1  system clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: ic_req_i  input  1  icache refill request, held until ic_ack_o or ic_kill_i.
REQ-005 Port: ic_addr_i  input  XLEN  icache refill physical address.
REQ-006 Port: ic_kill_i  input  1  icache abandons its request (fetch redirect).
REQ-007 Port: ic_ack_o  output  1  one-cycle response strobe to icache.
REQ-008 Port: ic_rdata_o  output  XLEN  response data to icache.
REQ-009 Port: ptw_req_i  input  1  MMU page-table-walk request, held until ptw_ack_o.
REQ-010 Port: ptw_addr_i  input  XLEN  PTW physical address.
REQ-011 Port: ptw_ack_o  output  1  one-cycle response strobe to PTW.
REQ-012 Port: ptw_rdata_o  output  XLEN  response data to PTW.
REQ-013 Port: mem_req_o  output  1  shared memory-port request.
REQ-014 Port: mem_addr_o  output  XLEN  shared memory-port address.
REQ-015 Port: mem_ack_i  input  1  memory response strobe, one per accepted request.
REQ-016 Port: mem_rdata_i  input  XLEN  memory response data, valid with mem_ack_i.

Function
REQ-017 FSM states SHALL be IDLE, BUSY_IC, BUSY_PTW, DRAIN.
REQ-018 IDLE: ic_req_i & ~ic_kill_i (icache eligible) or ptw_req_i -> grant at clock edge, latch address into mem_addr_o, enter BUSY_IC or BUSY_PTW.
REQ-019 Both eligible in IDLE: grant the requester not granted last; 1-bit last-grant register updated on every grant.
REQ-020 mem_req_o SHALL be 1 exactly in BUSY_IC, BUSY_PTW, DRAIN (registered; request at cycle N -> mem_req_o at N+1).
REQ-021 mem_addr_o SHALL hold constant from grant until the cycle after mem_ack_i.
REQ-022 BUSY_IC & mem_ack_i & ~ic_kill_i: ic_ack_o=1, ic_rdata_o=mem_rdata_i same cycle; next state IDLE.
REQ-023 BUSY_PTW & mem_ack_i: ptw_ack_o=1, ptw_rdata_o=mem_rdata_i same cycle; next state IDLE.
REQ-024 BUSY_IC & ic_kill_i & ~mem_ack_i: next state DRAIN; no ack issued.
REQ-025 BUSY_IC & ic_kill_i & mem_ack_i: ic_ack_o suppressed; next state IDLE.
REQ-026 DRAIN: mem_req_o held; mem_ack_i -> IDLE, response discarded, no ack to either side; ic_kill_i ignored.
REQ-027 ic_kill_i SHALL NOT affect a PTW transaction.
REQ-028 mem_ack_i in IDLE SHALL be ignored.
REQ-029 ic_rdata_o / ptw_rdata_o SHALL be 0 when the corresponding ack is 0.
REQ-030 At most one memory transaction outstanding; minimum spacing between acks 2 cycles (ack cycle + IDLE grant cycle).
REQ-031 ic_ack_o and ptw_ack_o SHALL never be 1 in the same cycle.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, mem_req_o=0, mem_addr_o=0, all acks 0, rdata outputs 0, last-grant=PTW (icache wins first tie).
REQ-033 Reset mid-transaction SHALL discard the outstanding transaction; a mem_ack_i arriving after reset release is ignored (IDLE).

Verification
REQ-034 ic_req_i=1, ic_addr_i=0x8000_0040 at cycle 0; mem_ack_i at cycle 3 with 0xDEAD_BEEF -> mem_req_o 1 cycles 1-3, ic_ack_o=1 and ic_rdata_o=0xDEAD_BEEF at cycle 3 only, mem_req_o=0 at cycle 4.
REQ-035 ic_req_i and ptw_req_i both held from reset release -> first grant icache, next grant PTW, then alternating; acks never overlap.
REQ-036 icache granted, ic_kill_i pulsed at cycle 2, mem_ack_i at cycle 5 -> state DRAIN cycles 3-5, no ic_ack_o, mem_req_o 0 at cycle 6, pending ptw_req_i granted at cycle 6 edge.
REQ-037 ic_kill_i coincident with mem_ack_i in BUSY_IC -> ic_ack_o stays 0, IDLE next cycle.
REQ-038 rst_n deasserted asynchronously mid-BUSY_PTW -> mem_req_o drops without clock edge; later mem_ack_i produces no ptw_ack_o.
